// File: rtl/milano_pkg.sv
// Shared widths and types for the milano integer register file.
package milano_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage : milano_pkg

// File: rtl/milano_regfile_rport.sv
// One register-file read port: address decode, x0 mask and optional write bypass.
module milano_regfile_rport
  import milano_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]       i_regs [NUM_REGS],
  input  logic                  i_byp_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [XLEN-1:0]       i_wdata,
  output logic [XLEN-1:0]       o_rdata
);

  logic w_valid;
  logic w_hit;

  assign w_valid = (i_addr != '0) && (32'(i_addr) < NUM_REGS);
  assign w_hit   = (BYPASS_EN != 0) && i_byp_we && (i_waddr == i_addr);

  // x0 and out-of-range addresses read as zero; a matching write overrides storage.
  always_comb begin
    o_rdata = '0;
    if (w_valid) begin
      o_rdata = w_hit ? i_wdata : i_regs[i_addr];
    end
  end

endmodule : milano_regfile_rport

// File: rtl/milano_regfile.sv
// Integer register file x0..x31: one write port, two ALU read ports, one debug port.
module milano_regfile
  import milano_pkg::*;
#(
  parameter int unsigned XLEN      = milano_pkg::XLEN,
  parameter int unsigned NUM_REGS  = milano_pkg::NUM_REGS,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  reg_addr_t       rs1_addr_i,
  output logic [XLEN-1:0] rs1_rdata_o,
  input  reg_addr_t       rs2_addr_i,
  output logic [XLEN-1:0] rs2_rdata_o,
  input  logic            we_i,
  input  reg_addr_t       waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  reg_addr_t       dbg_addr_i,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic [31:0]     wr_cnt_o
);

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic            w_we;
  logic            w_byp_we;
  logic [XLEN-1:0] r_regs [NUM_REGS-1:1];
  logic [XLEN-1:0] w_regs [NUM_REGS];
  logic [31:0]     r_wr_cnt;

  // Reset asserts immediately, releases two clocks after rst_ni rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n  = r_rst_sync[1];
  assign w_byp_we = we_i && w_rst_n;
  assign w_we     = w_byp_we && (waddr_i != '0) && (32'(waddr_i) < NUM_REGS);

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
      r_wr_cnt <= '0;
    end else begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (w_we && (waddr_i == REG_ADDR_W'(i))) begin
          r_regs[i] <= wdata_i;
        end
      end
      if (w_we) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

  // x0 has no storage; present it to the read ports as a constant zero slot.
  always_comb begin
    w_regs[0] = '0;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      w_regs[i] = r_regs[i];
    end
  end

  milano_regfile_rport #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS_EN(BYPASS_EN)
  ) u_rport_rs1 (
    .i_addr  (rs1_addr_i),
    .i_regs  (w_regs),
    .i_byp_we(w_byp_we),
    .i_waddr (waddr_i),
    .i_wdata (wdata_i),
    .o_rdata (rs1_rdata_o)
  );

  milano_regfile_rport #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS_EN(BYPASS_EN)
  ) u_rport_rs2 (
    .i_addr  (rs2_addr_i),
    .i_regs  (w_regs),
    .i_byp_we(w_byp_we),
    .i_waddr (waddr_i),
    .i_wdata (wdata_i),
    .o_rdata (rs2_rdata_o)
  );

  milano_regfile_rport #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS_EN(0)
  ) u_rport_dbg (
    .i_addr  (dbg_addr_i),
    .i_regs  (w_regs),
    .i_byp_we(1'b0),
    .i_waddr ('0),
    .i_wdata ('0),
    .o_rdata (dbg_rdata_o)
  );

  assign wr_cnt_o = r_wr_cnt;

  a_waddr_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    we_i |-> !$isunknown(waddr_i));

endmodule : milano_regfile

// File: tb/tb_milano_regfile.sv
// Directed bench for milano_regfile; bypass and non-bypass instances share stimulus.
module tb_milano_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, waddr, dbg_addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] b_rs1, b_rs2, b_dbg, b_cnt;
  logic [31:0] n_rs1, n_rs2, n_dbg, n_cnt;
  int          n_checks;
  int          n_errors;

  milano_regfile #(.BYPASS_EN(1)) u_byp (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_addr_i(rs1_addr), .rs1_rdata_o(b_rs1),
    .rs2_addr_i(rs2_addr), .rs2_rdata_o(b_rs2),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .dbg_addr_i(dbg_addr), .dbg_rdata_o(b_dbg),
    .wr_cnt_o(b_cnt)
  );

  milano_regfile #(.BYPASS_EN(0)) u_nobyp (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_addr_i(rs1_addr), .rs1_rdata_o(n_rs1),
    .rs2_addr_i(rs2_addr), .rs2_rdata_o(n_rs2),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .dbg_addr_i(dbg_addr), .dbg_rdata_o(n_dbg),
    .wr_cnt_o(n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one write for a single clock edge, then idle the port.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    rs1_addr = 5'd5; dbg_addr = 5'd5; #1;
    check("rst_rs1", b_rs1, 32'h0);
    check("rst_dbg", b_dbg, 32'h0);
    check("rst_cnt", b_cnt, 32'h0);
    release_reset();

    // 1: mid-cycle reset clears storage and counter at once
    write_reg(5'd5, 32'h0000_1234);
    #1;
    check("t1_x5_loaded", b_dbg, 32'h0000_1234);
    check("t1_cnt_loaded", b_cnt, 32'd1);
    #2 rst_n = 1'b0; #1;
    check("t1_x5_rst_byp", b_dbg, 32'h0);
    check("t1_x5_rst_nobyp", n_dbg, 32'h0);
    check("t1_rs1_rst", b_rs1, 32'h0);
    check("t1_cnt_rst", b_cnt, 32'h0);

    // 6: write during reset is dropped and not bypassed
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_00A5; rs2_addr = 5'd9; #1;
    check("t6_rs2_rst_bypass", b_rs2, 32'h0);
    @(negedge clk);
    we = 1'b0;
    release_reset();
    dbg_addr = 5'd9; #1;
    check("t6_x9", b_dbg, 32'h0);
    check("t6_cnt", b_cnt, 32'h0);

    // 2: plain write then debug read
    dbg_addr = 5'd3;
    write_reg(5'd3, 32'hDEAD_BEEF);
    #1;
    check("t2_dbg3", b_dbg, 32'hDEAD_BEEF);
    check("t2_dbg3_nobyp", n_dbg, 32'hDEAD_BEEF);
    check("t2_cnt", b_cnt, 32'd1);

    // 3: x0 writes are discarded and uncounted
    @(negedge clk);
    rs1_addr = 5'd0; we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; #1;
    check("t3_rs1_pre", b_rs1, 32'h0);
    @(negedge clk);
    we = 1'b0; #1;
    check("t3_rs1_post", b_rs1, 32'h0);
    check("t3_cnt", b_cnt, 32'd1);

    // 4: same-cycle bypass on both ports
    write_reg(5'd7, 32'h0000_0011);
    @(negedge clk);
    rs1_addr = 5'd7; rs2_addr = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0022; #1;
    check("t4_byp_rs1", b_rs1, 32'h22);
    check("t4_byp_rs2", b_rs2, 32'h22);
    check("t4_nobyp_rs1", n_rs1, 32'h11);
    check("t4_nobyp_rs2", n_rs2, 32'h11);
    @(negedge clk);
    we = 1'b0; #1;
    check("t4_nobyp_rs1_after", n_rs1, 32'h22);
    check("t4_nobyp_rs2_after", n_rs2, 32'h22);
    check("t4_cnt", n_cnt, 32'd3);

    // 5: ALU chain through the read ports
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd7);
    rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    write_reg(5'd3, b_rs1 + b_rs2);
    dbg_addr = 5'd3; #1;
    check("t5_add", b_dbg, 32'd12);
    rs1_addr = 5'd3; rs2_addr = 5'd1; #1;
    write_reg(5'd3, n_rs1 - n_rs2);
    #1;
    check("t5_sub", n_dbg, 32'd7);
    check("t5_cnt", b_cnt, 32'd7);

    // Back-to-back writes: last wins; single-port bypass hit
    rs1_addr = 5'd4; rs2_addr = 5'd2; dbg_addr = 5'd4;
    @(negedge clk);
    we = 1'b1; waddr = 5'd4; wdata = 32'h0000_00AA;
    @(negedge clk);
    wdata = 32'h0000_00BB; #1;
    check("b2b_rs1_byp", b_rs1, 32'hBB);
    check("b2b_rs1_nobyp", n_rs1, 32'hAA);
    check("b2b_rs2_nohit", b_rs2, 32'd7);
    @(negedge clk);
    we = 1'b0; #1;
    check("b2b_dbg", b_dbg, 32'hBB);
    check("b2b_cnt", b_cnt, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_milano_regfile
